// File: rtl/clk_div_multi_if.sv
// Control/status bundle for clk_div_multi: per-channel enables, divisor write port, tick/square outputs.
// Outputs are registered one cycle after the sampling edge; no backpressure, every write is answered by ack or err.
interface clk_div_multi_if #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 16
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [NUM_CH-1:0] en;
    logic              sync_clr;
    logic              cfg_wr;
    logic [CH_W-1:0]   cfg_ch;
    logic [CNT_W-1:0]  cfg_div;
    logic              cfg_ack;
    logic              cfg_err;
    logic [NUM_CH-1:0] tick;
    logic [NUM_CH-1:0] sq_out;

    modport master (
        output en, sync_clr, cfg_wr, cfg_ch, cfg_div,
        input  cfg_ack, cfg_err, tick, sq_out
    );

    modport slave (
        input  en, sync_clr, cfg_wr, cfg_ch, cfg_div,
        output cfg_ack, cfg_err, tick, sq_out
    );
endinterface

// File: rtl/clk_div_multi.sv
// NUM_CH clock-enable generators: one-cycle tick every div cycles plus a 50% square wave at half that rate.
// Outputs registered (1 cycle); no backpressure, divisor writes always answered next cycle and applied at wrap.
module clk_div_multi #(
    parameter int NUM_CH      = 4,
    parameter int CNT_W       = 16,
    parameter int DEFAULT_DIV = 50000
) (
    input  logic           clk_in,
    input  logic           rst_n,
    clk_div_multi_if.slave bus
);
    localparam int               CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [CNT_W-1:0] DEF_DIV  = CNT_W'(DEFAULT_DIV);
    localparam logic [CH_W:0]    CH_LIMIT = (CH_W + 1)'(NUM_CH);

    logic [CNT_W-1:0]  r_cnt    [NUM_CH];
    logic [CNT_W-1:0]  r_div    [NUM_CH];
    logic [CNT_W-1:0]  r_shadow [NUM_CH];
    logic [NUM_CH-1:0] r_pend;
    logic [NUM_CH-1:0] r_tick;
    logic [NUM_CH-1:0] r_sq;
    logic              r_ack;
    logic              r_err;
    logic              w_in_range;

    assign w_in_range = ({1'b0, bus.cfg_ch} < CH_LIMIT);

    // Active divisor only changes at a wrap or while the counter is parked at 0,
    // so cnt can never sit above div-1 and the tick/square outputs never glitch.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_cnt[i]    <= '0;
                r_div[i]    <= DEF_DIV;
                r_shadow[i] <= DEF_DIV;
            end
            r_pend <= '0;
            r_tick <= '0;
            r_sq   <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_tick[i] <= 1'b0;
                if (bus.sync_clr) begin
                    r_cnt[i] <= '0;
                    r_sq[i]  <= 1'b0;
                    if (r_pend[i]) begin
                        r_div[i]  <= r_shadow[i];
                        r_pend[i] <= 1'b0;
                    end
                end else if (!bus.en[i]) begin
                    if (r_pend[i]) begin
                        r_div[i]  <= r_shadow[i];
                        r_pend[i] <= 1'b0;
                        r_cnt[i]  <= '0;
                    end
                end else if (r_div[i] == '0) begin
                    r_cnt[i] <= '0;
                    if (r_pend[i]) begin
                        r_div[i]  <= r_shadow[i];
                        r_pend[i] <= 1'b0;
                    end
                end else if (r_cnt[i] == r_div[i] - CNT_W'(1)) begin
                    r_cnt[i]  <= '0;
                    r_tick[i] <= 1'b1;
                    r_sq[i]   <= ~r_sq[i];
                    if (r_pend[i]) begin
                        r_div[i]  <= r_shadow[i];
                        r_pend[i] <= 1'b0;
                    end
                end else begin
                    r_cnt[i] <= r_cnt[i] + CNT_W'(1);
                end

                // Placed last so a write on a wrap/clear edge re-arms pend after the old shadow loads.
                if (bus.cfg_wr && w_in_range && (bus.cfg_ch == CH_W'(i))) begin
                    r_shadow[i] <= bus.cfg_div;
                    r_pend[i]   <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            r_ack <= 1'b0;
            r_err <= 1'b0;
        end else begin
            r_ack <= bus.cfg_wr & w_in_range;
            r_err <= bus.cfg_wr & ~w_in_range;
        end
    end

    assign bus.tick    = r_tick;
    assign bus.sq_out  = r_sq;
    assign bus.cfg_ack = r_ack;
    assign bus.cfg_err = r_err;
endmodule

// File: tb/tb_clk_div_multi.sv
// Scoreboard bench for clk_div_multi: driver pushes per-cycle expectations from a tick-interval model,
// monitor pops and compares them after every rising edge.
module tb_clk_div_multi;
    localparam int N   = 3;
    localparam int W   = 8;
    localparam int DEF = 6;
    localparam int CHW = 2;
    localparam int VW  = 2 * N + 2;

    logic clk_in;
    logic rst_n;
    int   n_tests;
    int   n_fail;
    int   n_cyc;

    clk_div_multi_if #(.NUM_CH(N), .CNT_W(W)) bus ();

    clk_div_multi #(.NUM_CH(N), .CNT_W(W), .DEFAULT_DIV(DEF)) dut (
        .clk_in (clk_in),
        .rst_n  (rst_n),
        .bus    (bus)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    // Reference model: each channel counts enabled cycles since its last tick and
    // ticks when that count reaches its divisor; a queued divisor takes over at a tick or while idle.
    int          m_div     [N];
    int          m_shadow  [N];
    int          m_elapsed [N];
    bit          m_pend    [N];
    bit          m_sq      [N];
    logic [VW-1:0] sb_q [$];

    function automatic void model_reset();
        for (int c = 0; c < N; c++) begin
            m_div[c] = DEF; m_shadow[c] = DEF; m_elapsed[c] = 0;
            m_pend[c] = 1'b0; m_sq[c] = 1'b0;
        end
    endfunction

    function automatic void take_pending(input int c);
        if (m_pend[c]) begin
            m_div[c]  = m_shadow[c];
            m_pend[c] = 1'b0;
            m_elapsed[c] = 0;
        end
    endfunction

    task automatic drive(input logic [N-1:0] e, input logic sc, input logic wr,
                         input int ch, input int dv);
        logic [N-1:0] t_exp;
        logic [N-1:0] s_exp;
        bit ack_e, err_e;
        bus.en = e; bus.sync_clr = sc; bus.cfg_wr = wr;
        bus.cfg_ch = CHW'(ch); bus.cfg_div = W'(dv);
        ack_e = wr && (ch < N);
        err_e = wr && (ch >= N);
        t_exp = '0;
        for (int c = 0; c < N; c++) begin
            if (sc) begin
                m_elapsed[c] = 0; m_sq[c] = 1'b0;
                take_pending(c);
            end else if (!e[c] || m_div[c] == 0) begin
                take_pending(c);
            end else begin
                m_elapsed[c]++;
                if (m_elapsed[c] == m_div[c]) begin
                    t_exp[c] = 1'b1;
                    m_sq[c]  = !m_sq[c];
                    m_elapsed[c] = 0;
                    take_pending(c);
                end
            end
            if (ack_e && ch == c) begin
                m_shadow[c] = dv;
                m_pend[c]   = 1'b1;
            end
            s_exp[c] = m_sq[c];
        end
        sb_q.push_back({ack_e, err_e, s_exp, t_exp});
    endtask

    task automatic cyc(input logic [N-1:0] e, input logic sc, input logic wr,
                       input int ch, input int dv);
        @(negedge clk_in);
        drive(e, sc, wr, ch, dv);
    endtask

    task automatic idle(input logic [N-1:0] e, input int n);
        for (int k = 0; k < n; k++) cyc(e, 1'b0, 1'b0, 0, 0);
    endtask

    task automatic chk(input string name, input logic [VW-1:0] got, input logic [VW-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%b exp=%b", name, got, exp);
        end
    endtask

    // Monitor: one expectation per edge, compared away from the edge.
    always @(posedge clk_in) begin
        #2;
        n_cyc++;
        if (sb_q.size() > 0) begin
            logic [VW-1:0] e;
            e = sb_q.pop_front();
            chk($sformatf("cyc%0d {ack,err,sq,tick}", n_cyc),
                {bus.cfg_ack, bus.cfg_err, bus.sq_out, bus.tick}, e);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end

    initial begin
        n_tests = 0; n_fail = 0; n_cyc = 0;
        rst_n = 1'b0;
        bus.en = '0; bus.sync_clr = 1'b0; bus.cfg_wr = 1'b0; bus.cfg_ch = '0; bus.cfg_div = '0;
        model_reset();
        #3;
        chk("reset outputs", {bus.cfg_ack, bus.cfg_err, bus.sq_out, bus.tick}, '0);

        @(negedge clk_in);
        rst_n = 1'b1;
        drive(3'b001, 1'b0, 1'b0, 0, 0);
        idle(3'b001, 40);                       // ch0 alone at the default divisor

        idle(3'b111, 3);
        cyc(3'b111, 1'b0, 1'b1, 1, 4);          // mid-count write to ch1
        idle(3'b111, 30);

        cyc(3'b111, 1'b0, 1'b1, 0, 1);          // div=1
        idle(3'b111, 20);
        cyc(3'b111, 1'b0, 1'b1, 0, 0);          // halt
        idle(3'b111, 15);
        cyc(3'b111, 1'b0, 1'b1, 0, 3);          // restart from halt
        idle(3'b111, 20);

        cyc(3'b111, 1'b0, 1'b1, 3, 2);          // out-of-range channel
        idle(3'b111, 20);

        cyc(3'b111, 1'b0, 1'b1, 2, 5);          // last write wins
        cyc(3'b111, 1'b0, 1'b1, 2, 7);
        idle(3'b111, 40);

        for (int k = 0; k < 20 && m_elapsed[2] != m_div[2] - 1; k++) idle(3'b111, 1);
        cyc(3'b111, 1'b0, 1'b1, 2, 2);          // write on the wrap edge
        idle(3'b111, 30);

        idle(3'b101, 10);                       // ch1 paused
        idle(3'b111, 20);
        cyc(3'b111, 1'b0, 1'b1, 1, 3);
        idle(3'b101, 5);                        // pending load while paused
        idle(3'b111, 15);

        cyc(3'b111, 1'b1, 1'b1, 0, 5);          // sync_clr with a write in the same cycle
        idle(3'b111, 30);

        for (int k = 0; k < 1500; k++) begin
            logic [N-1:0] e;
            for (int c = 0; c < N; c++) e[c] = ($urandom_range(0, 99) < 85);
            cyc(e, $urandom_range(0, 99) < 2, $urandom_range(0, 99) < 15,
                int'($urandom_range(0, 3)), int'($urandom_range(0, 9)));
        end

        // Asynchronous reset mid-count with a write in flight.
        @(negedge clk_in);
        bus.en = 3'b111; bus.sync_clr = 1'b0; bus.cfg_wr = 1'b1; bus.cfg_ch = 2'd1; bus.cfg_div = 8'd2;
        #2 rst_n = 1'b0;
        #1;
        chk("async rst tick",  {{(VW-N){1'b0}}, bus.tick}, '0);
        chk("async rst sq",    {{(VW-N){1'b0}}, bus.sq_out}, '0);
        chk("async rst ack",   {{(VW-1){1'b0}}, bus.cfg_ack}, '0);
        chk("async rst err",   {{(VW-1){1'b0}}, bus.cfg_err}, '0);
        @(negedge clk_in);
        @(negedge clk_in);
        chk("held rst outputs", {bus.cfg_ack, bus.cfg_err, bus.sq_out, bus.tick}, '0);
        rst_n = 1'b1;
        model_reset();
        drive(3'b111, 1'b0, 1'b0, 0, 0);
        idle(3'b111, 30);

        @(posedge clk_in);
        #3;
        chk("scoreboard drained", VW'(sb_q.size()), '0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
